// File: rtl/noise_share_scheduler.sv
// Round-robin distribution of one signed noise stream across NUM_CH consumer channels.
// Output stays idle for a fixed warm-up after reset. After that, at most one channel is granted per cycle.
module noise_share_scheduler #(
  parameter int unsigned NUM_CH        = 4,
  parameter int unsigned CH_IDX_BITS   = 2,
  parameter int unsigned NOISE_BITS    = 15,
  parameter int unsigned WARMUP_CYCLES = 16,
  parameter int unsigned CNT_BITS      = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic signed [NOISE_BITS-1:0] noise_in,
  input  logic        [NUM_CH-1:0]     ch_enable,
  input  logic        [NUM_CH-1:0]     req,
  input  logic                         freeze,
  output logic        [NUM_CH-1:0]     gnt,
  output logic signed [NOISE_BITS-1:0] noise_out,
  output logic        [CH_IDX_BITS-1:0] noise_ch,
  output logic                         noise_valid,
  output logic                         ready,
  output logic        [CNT_BITS-1:0]   grant_count
);

  typedef enum logic [0:0] {StWarmup, StRun} state_e;

  localparam logic [7:0]             WarmupLast = 8'(WARMUP_CYCLES - 1);
  localparam logic [CH_IDX_BITS-1:0] LastCh     = CH_IDX_BITS'(NUM_CH - 1);
  localparam logic [NUM_CH-1:0]      OneHot0    = NUM_CH'(1);

  state_e                  state_q;
  logic [7:0]              warm_cnt_q;
  logic [CH_IDX_BITS-1:0]  ptr_q, ptr_d;
  logic [NUM_CH-1:0]       gnt_q, gnt_d;
  logic signed [NOISE_BITS-1:0] noise_out_q;
  logic [CH_IDX_BITS-1:0]  noise_ch_q;
  logic                    valid_q;
  logic                    ready_q;
  logic [CNT_BITS-1:0]     cnt_q, cnt_d;

  logic [NUM_CH-1:0]       eligible;
  logic                    grant_ok;
  logic                    found;
  logic [CH_IDX_BITS-1:0]  pick;
  logic [CH_IDX_BITS-1:0]  cand;
  int unsigned             idx;

  assign eligible = req & ch_enable;
  assign grant_ok = !freeze && (|eligible);

  // Scan from the pointer upward, wrapping at NUM_CH-1; the first eligible channel wins.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    idx   = 0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      idx = 32'(ptr_q) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      cand = CH_IDX_BITS'(idx);
      if (!found && eligible[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    ptr_d = (pick == LastCh) ? '0 : pick + CH_IDX_BITS'(1);
    gnt_d = OneHot0 << pick;
    cnt_d = cnt_q + CNT_BITS'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StWarmup;
      warm_cnt_q  <= '0;
      ptr_q       <= '0;
      gnt_q       <= '0;
      noise_out_q <= '0;
      noise_ch_q  <= '0;
      valid_q     <= 1'b0;
      ready_q     <= 1'b0;
      cnt_q       <= '0;
    end else begin
      unique case (state_q)
        StWarmup: begin
          if (warm_cnt_q == WarmupLast) begin
            state_q <= StRun;
            ready_q <= 1'b1;
          end else begin
            warm_cnt_q <= warm_cnt_q + 8'd1;
          end
        end
        StRun: begin
          if (grant_ok) begin
            gnt_q       <= gnt_d;
            valid_q     <= 1'b1;
            noise_out_q <= noise_in;
            noise_ch_q  <= pick;
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_d;
          end else begin
            // Sample is dropped; noise_out and noise_ch keep the last delivered values.
            gnt_q   <= '0;
            valid_q <= 1'b0;
          end
        end
        default: state_q <= StWarmup;
      endcase
    end
  end

  assign gnt         = gnt_q;
  assign noise_out   = noise_out_q;
  assign noise_ch    = noise_ch_q;
  assign noise_valid = valid_q;
  assign ready       = ready_q;
  assign grant_count = cnt_q;

endmodule

// File: tb/tb_noise_share_scheduler.sv
// Directed bench for noise_share_scheduler with hand-computed expectations.
// The grant counter is built 4 bits wide so that its wrap can be exercised.
module tb_noise_share_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [14:0] noise_in;
  logic [3:0]  ch_enable;
  logic [3:0]  req;
  logic        freeze;
  logic [3:0]  gnt;
  logic [14:0] noise_out;
  logic [1:0]  noise_ch;
  logic        noise_valid;
  logic        ready;
  logic [3:0]  grant_count;

  int checks = 0;
  int errors = 0;

  noise_share_scheduler #(
    .NUM_CH       (4),
    .CH_IDX_BITS  (2),
    .NOISE_BITS   (15),
    .WARMUP_CYCLES(16),
    .CNT_BITS     (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .noise_in   (noise_in),
    .ch_enable  (ch_enable),
    .req        (req),
    .freeze     (freeze),
    .gnt        (gnt),
    .noise_out  (noise_out),
    .noise_ch   (noise_ch),
    .noise_valid(noise_valid),
    .ready      (ready),
    .grant_count(grant_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_grant(input string tag, input logic [3:0] g, input logic [1:0] ch,
                             input logic [14:0] nout, input logic [3:0] cnt);
    check({tag, ".gnt"},   32'(gnt),         32'(g));
    check({tag, ".valid"}, 32'(noise_valid), 32'(g != 4'b0000));
    check({tag, ".ch"},    32'(noise_ch),    32'(ch));
    check({tag, ".nout"},  32'(noise_out),   32'(nout));
    check({tag, ".cnt"},   32'(grant_count), 32'(cnt));
  endtask

  initial begin
    rst       = 1'b0;
    noise_in  = 15'd0;
    ch_enable = 4'b1111;
    req       = 4'b1111;
    freeze    = 1'b0;

    for (int i = 0; i < 3; i++) tick();
    check("rst.ready", 32'(ready), 32'd0);
    check_grant("rst", 4'b0000, 2'd0, 15'd0, 4'd0);

    // Warm-up: ready low for the first 15 edges, high after the 16th.
    rst = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      check("warm.ready", 32'(ready), 32'd0);
      check("warm.gnt", 32'(gnt), 32'd0);
      check("warm.cnt", 32'(grant_count), 32'd0);
    end
    tick();
    check("warm.ready_rise", 32'(ready), 32'd1);
    check("warm.gnt_at_ready", 32'(gnt), 32'd0);

    // Round-robin with a ramping sample stream.
    for (int i = 0; i < 5; i++) begin
      noise_in = 15'(100 + i);
      tick();
      check_grant("rr", 4'(1 << (i % 4)), 2'(i % 4), 15'(100 + i), 4'(i + 1));
    end

    // Masking: only channel 1 is eligible (pointer is at 1).
    req       = 4'b1010;
    ch_enable = 4'b0010;
    noise_in  = 15'd200;
    tick(); check_grant("mask1a", 4'b0010, 2'd1, 15'd200, 4'd6);
    tick(); check_grant("mask1b", 4'b0010, 2'd1, 15'd200, 4'd7);
    tick(); check_grant("mask1c", 4'b0010, 2'd1, 15'd200, 4'd8);

    // Channels 1 and 3 alternate.
    ch_enable = 4'b1010;
    noise_in = 15'd301; tick(); check_grant("alt0", 4'b1000, 2'd3, 15'd301, 4'd9);
    noise_in = 15'd302; tick(); check_grant("alt1", 4'b0010, 2'd1, 15'd302, 4'd10);
    noise_in = 15'd303; tick(); check_grant("alt2", 4'b1000, 2'd3, 15'd303, 4'd11);
    noise_in = 15'd304; tick(); check_grant("alt3", 4'b0010, 2'd1, 15'd304, 4'd12);

    // Pointer is at 2: grant channel 2, then freeze with everyone requesting.
    req       = 4'b1111;
    ch_enable = 4'b1111;
    noise_in  = 15'd555;
    tick(); check_grant("pre_frz", 4'b0100, 2'd2, 15'd555, 4'd13);
    freeze = 1'b1;
    for (int i = 0; i < 4; i++) begin
      noise_in = 15'(600 + i);
      tick();
      check_grant("frz", 4'b0000, 2'd2, 15'd555, 4'd13);
    end
    freeze   = 1'b0;
    noise_in = 15'd700;
    tick(); check_grant("post_frz", 4'b1000, 2'd3, 15'd700, 4'd14);

    // Negative value passes bit-exact; counter wraps after 16 grants.
    noise_in = 15'h4000;
    tick(); check_grant("neg", 4'b0001, 2'd0, 15'h4000, 4'd15);
    noise_in = 15'h7fff;
    tick(); check_grant("wrap0", 4'b0010, 2'd1, 15'h7fff, 4'd0);
    noise_in = 15'h0123;
    tick(); check_grant("wrap1", 4'b0100, 2'd2, 15'h0123, 4'd1);

    // No eligible channel: idle, outputs hold.
    req      = 4'b0000;
    noise_in = 15'd999;
    tick(); check_grant("idle", 4'b0000, 2'd2, 15'h0123, 4'd1);

    // Mid-run reset while grants stream; freeze during warm-up must not matter.
    req      = 4'b1111;
    noise_in = 15'd42;
    tick(); check_grant("stream", 4'b1000, 2'd3, 15'd42, 4'd2);
    rst = 1'b0;
    tick();
    check("mrst.ready", 32'(ready), 32'd0);
    check_grant("mrst", 4'b0000, 2'd0, 15'd0, 4'd0);
    rst    = 1'b1;
    freeze = 1'b1;
    for (int i = 0; i < 15; i++) tick();
    check("mrst.ready15", 32'(ready), 32'd0);
    check("mrst.gnt15", 32'(gnt), 32'd0);
    tick();
    check("mrst.ready16", 32'(ready), 32'd1);
    freeze   = 1'b0;
    noise_in = 15'd77;
    tick(); check_grant("mrst.first", 4'b0001, 2'd0, 15'd77, 4'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
